// File: rtl/enum_type.sv
// Shared command encoding and default queue depth for the game engine command path.
package enum_type;

    localparam int unsigned QSIZE    = 8;
    localparam int unsigned GRAV_SRC = 2;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        DOWN   = 3'd3,
        ROTATE = 3'd4,
        DROP   = 3'd5
    } state_type;

endpackage

// File: rtl/cmd_arbiter_if.sv
// Requester/engine side of the command arbiter: per-source requests in, FIFO head out.
interface cmd_arbiter_if #(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned QSIZE = enum_type::QSIZE
);
    import enum_type::*;

    logic                       flush;
    logic [NSRC-1:0]            src_valid;
    state_type [NSRC-1:0]       src_cmd;
    logic [NSRC-1:0]            src_ready;
    logic                       cmd_valid;
    state_type                  cmd;
    logic                       cmd_ready;
    logic [$clog2(QSIZE):0]     occupancy;
    logic [7:0]                 drop_cnt;

    modport master (
        output flush, src_valid, src_cmd, cmd_ready,
        input  src_ready, cmd_valid, cmd, occupancy, drop_cnt
    );

    modport slave (
        input  flush, src_valid, src_cmd, cmd_ready,
        output src_ready, cmd_valid, cmd, occupancy, drop_cnt
    );

endinterface

// File: rtl/cmd_fifo.sv
// Tagged command FIFO: each entry holds a command and the index of the source that sent it.
module cmd_fifo
    import enum_type::*;
#(
    parameter int unsigned QSIZE = enum_type::QSIZE,
    parameter int unsigned TW    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push,
    input  state_type               push_cmd,
    input  logic [TW-1:0]           push_tag,
    input  logic                    pop,
    output state_type               head_cmd,
    output logic [TW-1:0]           head_tag,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(QSIZE):0]  count
);
    localparam int unsigned AW = $clog2(QSIZE);

    typedef struct packed {
        state_type     cmd;
        logic [TW-1:0] tag;
    } entry_t;

    entry_t          mem_q [QSIZE];
    entry_t          mem_d [QSIZE];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    always_comb begin
        full     = (cnt_q == (AW+1)'(QSIZE));
        empty    = (cnt_q == '0);
        count    = cnt_q;
        head_cmd = mem_q[rd_ptr_q].cmd;
        head_tag = mem_q[rd_ptr_q].tag;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = '{cmd: push_cmd, tag: push_tag};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter feeding the game engine command FIFO, with gravity-request coalescing.
module cmd_arbiter
    import enum_type::*;
#(
    parameter int unsigned QSIZE = enum_type::QSIZE,
    parameter int unsigned NSRC  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    cmd_arbiter_if.slave bus
);
    localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CW = $clog2(QSIZE) + 1;

    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           grav_pend_q, grav_pend_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;

    logic           gnt_any;
    logic [PW-1:0]  gnt_idx, cand;
    state_type      gnt_cmd;
    logic           coalesce, skip, accept, push, pop;

    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    state_type      head_cmd;
    logic [PW-1:0]  head_tag;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            cand = PW'((32'(rr_ptr_q) + k) % NSRC);
            if (!gnt_any && bus.src_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_cmd = bus.src_cmd[gnt_idx];
    end

    // NONE and coalesced gravity requests need no slot, so they are acknowledged even when full.
    always_comb begin
        pop      = !fifo_empty && bus.cmd_ready && !bus.flush && reset_n;
        coalesce = (gnt_cmd == DOWN) && (gnt_idx == PW'(GRAV_SRC)) && grav_pend_q;
        skip     = (gnt_cmd == NONE) || coalesce;
        accept   = reset_n && !bus.flush && gnt_any && (skip || !fifo_full || pop);
        push     = accept && !skip;

        bus.src_ready = '0;
        if (accept) bus.src_ready[gnt_idx] = 1'b1;

        rr_ptr_d    = rr_ptr_q;
        grav_pend_d = grav_pend_q;
        drop_cnt_d  = drop_cnt_q;
        if (bus.flush) begin
            rr_ptr_d    = '0;
            grav_pend_d = 1'b0;
        end else begin
            if (accept) rr_ptr_d = PW'((32'(gnt_idx) + 1) % NSRC);
            if (pop && head_cmd == DOWN && head_tag == PW'(GRAV_SRC)) grav_pend_d = 1'b0;
            if (push && gnt_cmd == DOWN && gnt_idx == PW'(GRAV_SRC)) grav_pend_d = 1'b1;
            if (accept && coalesce && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            grav_pend_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grav_pend_q <= grav_pend_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    cmd_fifo #(
        .QSIZE (QSIZE),
        .TW    (PW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (bus.flush),
        .push     (push),
        .push_cmd (gnt_cmd),
        .push_tag (gnt_idx),
        .pop      (pop),
        .head_cmd (head_cmd),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        bus.cmd_valid = !fifo_empty;
        bus.cmd       = fifo_empty ? NONE : head_cmd;
        bus.occupancy = fifo_count;
        bus.drop_cnt  = drop_cnt_q;
    end

endmodule
